// File: rtl/synth_cfg_pkg.sv
// Shared constants, field layout and FSM state type for the synth configuration bus.
// Consumers: synth_cfg_writer and cfg_byte_pick.
package synth_cfg_pkg;

    localparam int CFG_BYTES = 6;
    localparam int CFG_BITS  = 48;

    localparam logic [CFG_BITS-1:0] CFG_RESET = 48'h0838_0638_0638;

    localparam int SAW_LO   = 0;
    localparam int OSC_LO   = 16;
    localparam int DAMP_LO  = 32;
    localparam int PERIOD_W = 9;
    localparam int OCT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } cfg_state_t;

    // One bit per byte lane that differs between the new word and what the synth holds.
    function automatic logic [CFG_BYTES-1:0] dirty_mask(
        input logic [CFG_BITS-1:0] word,
        input logic [CFG_BITS-1:0] shadow
    );
        logic [CFG_BYTES-1:0] mask;
        mask = {CFG_BYTES{1'b0}};
        for (int i = 0; i < CFG_BYTES; i++) begin
            mask[i] = (word[i*8 +: 8] != shadow[i*8 +: 8]);
        end
        return mask;
    endfunction

endpackage

// File: rtl/synth_cfg_writer_pick.sv
// Lowest-set-bit picker: pending byte mask -> byte index and one-hot enable.
module cfg_byte_pick
    import synth_cfg_pkg::*;
(
    input  logic [CFG_BYTES-1:0] pend,
    output logic [2:0]           idx,
    output logic [CFG_BYTES-1:0] onehot
);

    logic [CFG_BYTES-1:0] low_s;

    // Isolate the lowest set bit, then encode it.
    always_comb begin
        low_s = pend & (~pend + 6'd1);
        case (low_s)
            6'b000001: idx = 3'd0;
            6'b000010: idx = 3'd1;
            6'b000100: idx = 3'd2;
            6'b001000: idx = 3'd3;
            6'b010000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        onehot = low_s;
    end

endmodule

// File: rtl/synth_cfg_writer.sv
// Writer end of the synth byte-strobed config bus: accepts 48-bit words, replays changed bytes as paced writes.
// Build option: define SYNTH_CFG_WRITER_DIRTY_EN to write only bytes differing from the shadow (or all on flush).
module synth_cfg_writer
    import synth_cfg_pkg::*;
#(
    parameter int CFG_BYTES  = synth_cfg_pkg::CFG_BYTES,
    parameter int GAP_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_BYTES*8-1:0] cfg_data,
    input  logic                   flush,
    output logic [7:0]             cfg_out,
    output logic [CFG_BYTES-1:0]   cfg_we,
    output logic                   busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    cfg_state_t             state_r;
    logic [CFG_BITS-1:0]    shadow_r;
    logic [CFG_BITS-1:0]    word_r;
    logic [CFG_BYTES-1:0]   pend_r;
    logic [GAP_W-1:0]       gap_r;
    logic [7:0]             cfg_out_r;
    logic [CFG_BYTES-1:0]   cfg_we_r;
    logic                   ready_r;
    logic                   busy_r;

    logic [2:0]             pick_idx_s;
    logic [CFG_BYTES-1:0]   pick_onehot_s;
    logic [CFG_BYTES-1:0]   new_pend_s;
    logic [CFG_BYTES-1:0]   pend_left_s;
    logic [5:0]             bit_base_s;

    cfg_byte_pick u_pick (
        .pend   (pend_r),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Bytes to write for an incoming word, and what is left after the current write.
    always_comb begin
`ifdef SYNTH_CFG_WRITER_DIRTY_EN
        new_pend_s = dirty_mask(cfg_data, shadow_r) | {CFG_BYTES{flush}};
`else
        new_pend_s = dirty_mask(cfg_data, shadow_r) | {CFG_BYTES{flush}} | {CFG_BYTES{1'b1}};
`endif
        pend_left_s = pend_r & ~pick_onehot_s;
        bit_base_s  = {pick_idx_s, 3'b000};
    end

    // Sequencer: accept, paced byte writes, shadow tracking; everything frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shadow_r  <= CFG_RESET;
            word_r    <= 48'h0;
            pend_r    <= 6'b0;
            gap_r     <= {GAP_W{1'b0}};
            cfg_out_r <= 8'h00;
            cfg_we_r  <= 6'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else if (!ena) begin
            cfg_we_r <= 6'b0;
        end else begin
            cfg_we_r <= 6'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        word_r <= cfg_data;
                        if (new_pend_s != 6'b0) begin
                            pend_r  <= new_pend_s;
                            state_r <= WRITE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    cfg_out_r                 <= word_r[bit_base_s +: 8];
                    cfg_we_r                  <= pick_onehot_s;
                    shadow_r[bit_base_s +: 8] <= word_r[bit_base_s +: 8];
                    pend_r                    <= pend_left_s;
                    if (pend_left_s == 6'b0) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (GAP_CYCLES == 0) begin
                        state_r <= WRITE;
                    end else begin
                        state_r <= GAP;
                        gap_r   <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    if (gap_r == {GAP_W{1'b0}}) begin
                        state_r <= WRITE;
                    end else begin
                        gap_r <= gap_r - GAP_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pend_r  <= 6'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // The handshake must not complete while the block is disabled.
    assign cfg_ready = ready_r & ena;
    assign cfg_out   = cfg_out_r;
    assign cfg_we    = cfg_we_r;
    assign busy      = busy_r;

endmodule
